// File: rtl/traceback_unit_if.sv
// Column/symbol bus between the ACS stage, traceback_unit and the symbol sink.
// master drives the survivor columns and selected node; slave returns ready and decoded symbols.
interface traceback_unit_if #(
  parameter int STATE_NUM = 256,
  parameter int STATE_W   = 8
);
  logic                              en_tb;
  logic [STATE_NUM-1:0][STATE_W-1:0] i_fwd_prv_st;
  logic [STATE_W-1:0]                i_sel_node;
  logic                              i_last;
  logic                              o_ready;
  logic                              o_valid;
  logic [1:0]                        o_data;
  logic                              o_last;

  modport master (
    output en_tb, i_fwd_prv_st, i_sel_node, i_last,
    input  o_ready, o_valid, o_data, o_last
  );

  modport slave (
    input  en_tb, i_fwd_prv_st, i_sel_node, i_last,
    output o_ready, o_valid, o_data, o_last
  );
endinterface

// File: rtl/traceback_unit.sv
// Viterbi survivor traceback: buffers up to TB_LEN pointer columns, traces back, emits symbols in forward order (TB_ZERO_TERM_EN: i_last blocks start from state 0).
// Latency 1+n+n cycles from closing column to o_last; o_ready low from block close until output ends, no output backpressure.
module traceback_unit #(
  parameter int STATE_NUM = 256,
  parameter int STATE_W   = 8,
  parameter int TB_LEN    = 16
) (
  input logic             clk,
  input logic             rst,
  traceback_unit_if.slave tb_if
);
  localparam int PTR_W = (TB_LEN > 1) ? $clog2(TB_LEN) : 1;
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(TB_LEN - 1);

  typedef logic [STATE_NUM-1:0][STATE_W-1:0] column_t;
  typedef enum logic [1:0] {FILL, LOCK, TRACE, OUTPUT} state_t;

  state_t             state, state_nxt;
  column_t            surv [TB_LEN];
  logic [1:0]         dec  [TB_LEN];
  logic [PTR_W-1:0]   wr_ptr, last_idx, tr_idx, out_idx, out_nxt;
  logic [STATE_W-1:0] cur, start_st;
  logic [1:0]         dec_sym;
  logic               accept, close, trace_done, out_done;
  logic               ready_q, valid_q, last_q;
  logic [1:0]         data_q;

  assign tb_if.o_ready = ready_q;
  assign tb_if.o_valid = valid_q;
  assign tb_if.o_data  = data_q;
  assign tb_if.o_last  = last_q;

  // Symbol bits come out swapped relative to the state LSBs.
  assign dec_sym = {cur[0], cur[1]};
  assign out_nxt = out_idx + 1'b1;

`ifdef TB_ZERO_TERM_EN
  logic frame_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_last <= 1'b0;
    end else if (close) begin
      frame_last <= tb_if.i_last;
    end
  end

  assign start_st = frame_last ? '0 : tb_if.i_sel_node;
`else
  assign start_st = tb_if.i_sel_node;
`endif

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    close      = 1'b0;
    trace_done = 1'b0;
    out_done   = 1'b0;
    unique case (state)
      FILL: begin
        accept = tb_if.en_tb && ready_q;
        close  = accept && (tb_if.i_last || (wr_ptr == LAST_SLOT));
        if (close) state_nxt = LOCK;
      end
      LOCK: state_nxt = TRACE;
      TRACE: begin
        trace_done = (tr_idx == '0);
        if (trace_done) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        out_done = (out_idx == last_idx);
        if (out_done) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Storage arrays are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept) surv[wr_ptr] <= tb_if.i_fwd_prv_st;
    if (state == TRACE) dec[tr_idx] <= dec_sym;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      last_idx <= '0;
      tr_idx   <= '0;
      out_idx  <= '0;
      cur      <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 2'b00;
      last_q   <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          ready_q <= !close;
          if (accept) begin
            wr_ptr   <= wr_ptr + 1'b1;
            last_idx <= wr_ptr;
          end
        end
        // ACS metric lags its pointers by a cycle, so the node sampled here matches the final column.
        LOCK: begin
          cur    <= start_st;
          tr_idx <= last_idx;
        end
        TRACE: begin
          cur    <= surv[tr_idx][cur];
          tr_idx <= tr_idx - 1'b1;
          if (trace_done) begin
            valid_q <= 1'b1;
            data_q  <= dec_sym;
            last_q  <= (last_idx == '0);
            out_idx <= '0;
          end
        end
        OUTPUT: begin
          if (out_done) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            wr_ptr  <= '0;
          end else begin
            out_idx <= out_nxt;
            data_q  <= dec[out_nxt];
            last_q  <= (out_nxt == last_idx);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/traceback_unit.md
Name: traceback_unit

Overview:
- Survivor-path traceback stage placed directly downstream of the add-compare-select stage in the radix-4, 256-state Viterbi decoder.
- Each enabled cycle it stores one column of per-state predecessor pointers (next-state index -> previous state) into a survivor buffer.
- When a block closes, it traces back from the best-metric node and emits the decoded 2-bit symbols in forward time order.

Parameters:
- STATE_NUM, 256, number of trellis states (columns are STATE_NUM entries wide)
- STATE_W, 8, bits per state index (log2 STATE_NUM)
- TB_LEN, 16, maximum columns per traceback block (survivor buffer depth)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- en_tb  input  1  column valid; a column is accepted only when en_tb && o_ready
- i_fwd_prv_st  input  STATE_NUM x STATE_W  predecessor pointer for each next state (index = next state, value = previous state)
- i_sel_node  input  STATE_W  index of the minimum-metric node
- i_last  input  1  end of frame, qualified by an accepted column
- o_ready  output  1  block accepts columns
- o_valid  output  1  o_data holds a decoded symbol
- o_data  output  2  decoded symbol
- o_last  output  1  final symbol of the block

Behaviour:
- Reset values: o_ready=0, o_valid=0, o_data=0, o_last=0. FSM goes to FILL; write pointer and count are 0. Survivor RAM contents are not reset.
- o_ready rises on the first clk edge after rst deasserts. A reset asserted at any point aborts the current block immediately; no partial output follows.
- FSM states: FILL, LOCK, TRACE, OUTPUT.
- FILL:
  - An accepted column is written to buffer slot wr_ptr; wr_ptr increments.
  - The block closes when the written column is slot TB_LEN-1, or when i_last=1 on an accepted column. The closing column is included.
  - Block length n = wr_ptr+1 (1..TB_LEN). On close: o_ready=0 from the next cycle; go to LOCK.
- LOCK (1 cycle): start state = i_sel_node sampled this cycle. The ACS node metric lags its pointers by one cycle, so this sample reflects the final column. The i_last flag is latched with the block. Go to TRACE.
- TRACE (n cycles, k = n-1 down to 0):
  - decoded[k] = {cur[0],cur[1]} (bit order reversed relative to the state LSBs).
  - Next cur = buf[k][cur].
  - After k=0, go to OUTPUT.
- OUTPUT (n cycles): emit decoded[0]..decoded[n-1], one per cycle, with o_valid=1. There is no output backpressure. o_last=1 together with decoded[n-1].
- The cycle after o_last: o_valid=0, o_last=0, o_ready=1, wr_ptr=0, state=FILL.
- o_data holds its last value when o_valid=0.
- en_tb while o_ready=0: ignored; no write, no pointer change. i_last on an unaccepted column is ignored.
- i_last=1 on slot TB_LEN-1: a single close; the frame flag is set.
- Total block latency from closing column to o_last: 1 + n + n cycles.

Optional Feature:
- Macro TB_ZERO_TERM_EN.
- Defined: for blocks closed by i_last, the start state is forced to 0 (tail-terminated encoder) and i_sel_node is ignored. Blocks closed by a full buffer still use i_sel_node.
- Not defined: every block starts from i_sel_node.

Test Plan:
1. Reset -> o_ready=0, o_valid=0, o_data=0. One edge after release, o_ready=1.
2. TB_LEN=4, every column i_fwd_prv_st[s]={s[5:0],s[7:6]}, i_last on column 4, i_sel_node=8'h01 in LOCK -> o_data sequence 00,00,00,10; o_last on the 4th symbol; o_ready=1 the following cycle.
3. Frame of 2 columns (i_last on the 2nd), same tables, i_sel_node=8'h02 -> outputs 00,01, then o_last.
4. en_tb=1 with random columns held throughout LOCK/TRACE/OUTPUT of case 2 -> decoded output unchanged, the next block starts at slot 0.
5. rst pulse mid-TRACE -> o_valid never asserts for that block; o_ready=1 one edge after release; the next block decodes correctly.
6. TB_ZERO_TERM_EN defined, case 2 stimulus with i_sel_node=8'h01 -> start state 0, outputs 00,00,00,00. Full-buffer block (no i_last) still follows i_sel_node.
